// File: rtl/occ_arb_pkg.sv
// Shared defaults and index helpers for the rom_Occ lane arbiter.
// Lane indices are carried at the widest supported width (8 lanes).
package occ_arb_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned IDX_W      = 3;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic [MAX_REQ-1:0] onehot(idx_t i);
    return MAX_REQ'(1) << i;
  endfunction

  function automatic idx_t next_idx(idx_t i, int unsigned n);
    return (32'(i) + 32'd1 >= n) ? '0 : i + idx_t'(1);
  endfunction

endpackage

// File: rtl/occ_rom_arbiter_if.sv
// Lane-side request/response bundle for the rom_Occ arbiter.
// Lane k's addresses are packed at [k*ADDR_W +: ADDR_W].
interface occ_rom_arbiter_if
  import occ_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*ADDR_W-1:0] req_addr1_i;
  logic [N_REQ*ADDR_W-1:0] req_addr2_i;
  logic [N_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]       rsp_data1_o;
  logic [DATA_W-1:0]       rsp_data2_o;

  modport master (
    output req_valid_i, req_addr1_i, req_addr2_i,
    input  req_ready_o, rsp_valid_o, rsp_data1_o, rsp_data2_o
  );

  modport slave (
    input  req_valid_i, req_addr1_i, req_addr2_i,
    output req_ready_o, rsp_valid_o, rsp_data1_o, rsp_data2_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after ptr_i, wrapping modulo N.
module rr_arbiter
  import occ_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req_i,
  input  idx_t         ptr_i,
  output logic [N-1:0] gnt_o,
  output idx_t         gnt_idx_o
);

  int unsigned w_j;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    w_j       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      w_j = (32'(ptr_i) + (N - 1 - off)) % N;
      if (req_i[w_j]) begin
        gnt_o      = '0;
        gnt_o[w_j] = 1'b1;
        gnt_idx_o  = idx_t'(w_j);
      end
    end
  end

endmodule

// File: rtl/occ_rom_arbiter.sv
// Shares one dual-address rom_Occ between N_REQ lanes: round-robin grant,
// registered ROM pins, response returned two edges after the transfer.
module occ_rom_arbiter
  import occ_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  occ_rom_arbiter_if.slave  bus,
  output logic              ce_rom_Occ_o,
  output logic [ADDR_W-1:0] addr1_rom_Occ_o,
  output logic [ADDR_W-1:0] addr2_rom_Occ_o,
  input  logic [DATA_W-1:0] data_1_i,
  input  logic [DATA_W-1:0] data_2_i,
  output logic [CNT_W-1:0]  lookup_cnt_o,
  output logic              idle_o
);

  logic [N_REQ-1:0]  w_gnt;
  idx_t              w_gnt_idx;
  logic              w_xfer;

  idx_t              r_ptr;
  logic              r_ce;
  logic [ADDR_W-1:0] r_addr1;
  logic [ADDR_W-1:0] r_addr2;
  idx_t              r_s1_id;
  logic              r_s1_v;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data1;
  logic [DATA_W-1:0] r_rsp_data2;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_idle;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req_i     (bus.req_valid_i),
    .ptr_i     (r_ptr),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  // Grant is only ever given to a valid lane, so any grant is a transfer.
  assign w_xfer = |w_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_ce        <= 1'b0;
      r_addr1     <= '0;
      r_addr2     <= '0;
      r_s1_id     <= '0;
      r_s1_v      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data1 <= '0;
      r_rsp_data2 <= '0;
      r_cnt       <= '0;
      r_idle      <= 1'b1;
    end else begin
      if (w_xfer) begin
        r_ptr   <= next_idx(w_gnt_idx, N_REQ);
        r_ce    <= 1'b1;
        r_addr1 <= bus.req_addr1_i[32'(w_gnt_idx)*ADDR_W +: ADDR_W];
        r_addr2 <= bus.req_addr2_i[32'(w_gnt_idx)*ADDR_W +: ADDR_W];
        r_s1_id <= w_gnt_idx;
        r_s1_v  <= 1'b1;
      end else begin
        r_ce   <= 1'b0;
        r_s1_v <= 1'b0;
      end

      if (r_s1_v) begin
        r_rsp_data1 <= data_1_i;
        r_rsp_data2 <= data_2_i;
        r_rsp_valid <= N_REQ'(1) << r_s1_id;
      end else begin
        r_rsp_valid <= '0;
      end

      if ((|r_rsp_valid) && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_idle <= ~r_s1_v & ~(|r_rsp_valid) & ~(|bus.req_valid_i);
    end
  end

  assign bus.req_ready_o = w_gnt;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_data1_o = r_rsp_data1;
  assign bus.rsp_data2_o = r_rsp_data2;
  assign ce_rom_Occ_o    = r_ce;
  assign addr1_rom_Occ_o = r_addr1;
  assign addr2_rom_Occ_o = r_addr2;
  assign lookup_cnt_o    = r_cnt;
  assign idle_o          = r_idle;

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Directed bench for occ_rom_arbiter with a combinational rom_Occ model.
// Built with CNT_W=4 so counter saturation is reachable quickly.
module tb_occ_rom_arbiter;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              ce;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [CNT_W-1:0]  cnt;
  logic              idle;

  int checks = 0;
  int errors = 0;

  occ_rom_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  occ_rom_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .ce_rom_Occ_o    (ce),
    .addr1_rom_Occ_o (a1),
    .addr2_rom_Occ_o (a2),
    .data_1_i        (d1),
    .data_2_i        (d2),
    .lookup_cnt_o    (cnt),
    .idle_o          (idle)
  );

  function automatic logic [31:0] rom1(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'd3};
  endfunction

  function automatic logic [31:0] rom2(input logic [7:0] a);
    return {a + 8'd7, a, 8'hC3, ~a};
  endfunction

  assign d1 = rom1(a1);
  assign d2 = rom2(a2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i = '0;
    bus.req_addr1_i = '0;
    bus.req_addr2_i = '0;
    tick();
    tick();
    check("rst_ready", 32'(bus.req_ready_o), 32'h0);
    check("rst_rspv", 32'(bus.rsp_valid_o), 32'h0);
    check("rst_data1", bus.rsp_data1_o, 32'h0);
    check("rst_data2", bus.rsp_data2_o, 32'h0);
    check("rst_ce", 32'(ce), 32'h0);
    check("rst_addr", 32'({a1, a2}), 32'h0);
    check("rst_cnt", 32'(cnt), 32'h0);
    check("rst_idle", 32'(idle), 32'h1);
    rst = 1'b0;

    // Single request on lane 2.
    bus.req_addr1_i = {8'h13, 8'h05, 8'h11, 8'h10};
    bus.req_addr2_i = {8'h23, 8'h0A, 8'h21, 8'h20};
    bus.req_valid_i = 4'b0100;
    #1;
    check("single_ready", 32'(bus.req_ready_o), 32'h4);
    tick();
    bus.req_valid_i = '0;
    check("single_ce", 32'(ce), 32'h1);
    check("single_a1", 32'(a1), 32'h05);
    check("single_a2", 32'(a2), 32'h0A);
    check("single_rspv_early", 32'(bus.rsp_valid_o), 32'h0);
    tick();
    check("single_rspv", 32'(bus.rsp_valid_o), 32'h4);
    check("single_d1", bus.rsp_data1_o, rom1(8'h05));
    check("single_d2", bus.rsp_data2_o, rom2(8'h0A));
    tick();
    check("single_rspv_pulse", 32'(bus.rsp_valid_o), 32'h0);
    check("single_cnt", 32'(cnt), 32'h1);

    // Reset with a lookup sitting in stage 1 (ptr is 3, lane 0 only).
    bus.req_addr2_i = {8'h23, 8'h22, 8'h21, 8'h20};
    bus.req_addr1_i = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid_i = 4'b0001;
    #1;
    check("wrap_ready", 32'(bus.req_ready_o), 32'h1);
    tick();
    bus.req_valid_i = '0;
    rst = 1'b1;
    #1;
    check("midrst_ce", 32'(ce), 32'h0);
    check("midrst_addr", 32'({a1, a2}), 32'h0);
    check("midrst_cnt", 32'(cnt), 32'h0);
    check("midrst_idle", 32'(idle), 32'h1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_rsp", 32'(bus.rsp_valid_o), 32'h0);
    end

    // All lanes valid for 8 cycles from ptr 0.
    bus.req_valid_i = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("all_ready", 32'(bus.req_ready_o), 32'(1) << (c % 4));
      tick();
      if (c >= 1) begin
        check("all_rspv", 32'(bus.rsp_valid_o), 32'(1) << ((c - 1) % 4));
        check("all_d1", bus.rsp_data1_o, rom1(8'h10 + 8'((c - 1) % 4)));
      end
    end
    bus.req_valid_i = '0;
    tick();
    check("all_rspv_last", 32'(bus.rsp_valid_o), 32'h8);
    check("all_d2_last", bus.rsp_data2_o, rom2(8'h23));
    tick();
    check("all_rspv_done", 32'(bus.rsp_valid_o), 32'h0);
    check("all_cnt", 32'(cnt), 32'h8);

    // Lane 1 alone moves ptr to 2; then lanes 1 and 3 alternate from lane 3.
    bus.req_valid_i = 4'b0010;
    #1;
    check("l1_ready", 32'(bus.req_ready_o), 32'h2);
    tick();
    bus.req_valid_i = 4'b1010;
    #1;
    check("pair_ready0", 32'(bus.req_ready_o), 32'h8);
    tick();
    check("pair_ready1", 32'(bus.req_ready_o), 32'h2);
    tick();
    check("pair_ready2", 32'(bus.req_ready_o), 32'h8);
    tick();
    bus.req_valid_i = '0;

    // Idle gap.
    tick();
    check("gap_rspv_lane3", 32'(bus.rsp_valid_o), 32'h8);
    tick();
    tick();
    check("gap_ce", 32'(ce), 32'h0);
    check("gap_a1_hold", 32'(a1), 32'h13);
    check("gap_a2_hold", 32'(a2), 32'h23);
    check("gap_rspv", 32'(bus.rsp_valid_o), 32'h0);
    check("gap_idle", 32'(idle), 32'h1);
    check("gap_cnt", 32'(cnt), 32'd12);

    // Single lane streaming: granted every cycle, counter saturates at 15.
    bus.req_valid_i = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("stream_ready", 32'(bus.req_ready_o), 32'h1);
      tick();
    end
    bus.req_valid_i = '0;
    tick();
    tick();
    tick();
    check("sat_cnt", 32'(cnt), 32'd15);
    check("sat_idle", 32'(idle), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/occ_rom_arbiter.md
Name: occ_rom_arbiter

Overview:
- Shares the single dual-address rom_Occ between N_REQ backward-search lanes (accelerator_fsm instances). Each lane issues Occ lookups (addr1, addr2) through a valid/ready handshake.
- The arbiter grants one lane per cycle, round-robin. It drives the rom_Occ ce and address pins from registers, then returns data_1/data_2 to the granted lane with a fixed 2-cycle latency.
- Fully pipelined: one lookup per cycle in aggregate.

Parameters:
- N_REQ, 4, number of requesting lanes (2..8).
- ADDR_W, 8, rom_Occ address width.
- DATA_W, 32, rom_Occ data width.
- CNT_W, 16, width of the lookup statistics counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid_i  in  N_REQ  lane k has a lookup pending.
- req_ready_o  out  N_REQ  one-hot grant; a transfer occurs on req_valid_i[k] & req_ready_o[k].
- req_addr1_i  in  N_REQ*ADDR_W  lane k addr1, at bits [k*ADDR_W +: ADDR_W].
- req_addr2_i  in  N_REQ*ADDR_W  lane k addr2, packed the same way.
- rsp_valid_o  out  N_REQ  one-cycle pulse: response for lane k is present.
- rsp_data1_o  out  DATA_W  shared response bus, Occ data_1.
- rsp_data2_o  out  DATA_W  shared response bus, Occ data_2.
- ce_rom_Occ_o  out  1  rom_Occ chip enable.
- addr1_rom_Occ_o  out  ADDR_W  rom_Occ addr_1.
- addr2_rom_Occ_o  out  ADDR_W  rom_Occ addr_2.
- data_1_i  in  DATA_W  rom_Occ data_1 (combinational ROM output).
- data_2_i  in  DATA_W  rom_Occ data_2.
- lookup_cnt_o  out  CNT_W  completed lookups, saturating.
- idle_o  out  1  high when no lookup is in flight and no request is valid.

Behaviour:
- Reset (async, immediate): all of the following are 0 and the RR pointer is 0.
  - req_ready_o, rsp_valid_o, rsp_data1_o, rsp_data2_o
  - ce_rom_Occ_o, addr1_rom_Occ_o, addr2_rom_Occ_o
  - lookup_cnt_o
  - idle_o = 1
  - In-flight lookups are dropped; no rsp_valid_o pulse follows reset release.
- Arbitration (combinational):
  - req_ready_o is one-hot: the first lane with req_valid_i set, searching ptr, ptr+1, ..., wrapping mod N_REQ.
  - req_ready_o is all-zero when no lane is valid.
  - ready never depends on a lane's own ready (no loops).
- Pointer update: on a transfer to lane g, ptr <= (g+1) mod N_REQ. With no transfer, ptr holds.
- Stage 1 (edge E0, transfer to lane g):
  - ce_rom_Occ_o <= 1; addr1/addr2_rom_Occ_o <= lane g addresses; s1_id <= g; s1_v <= 1.
  - With no transfer: ce_rom_Occ_o <= 0, s1_v <= 0, address regs hold their last value.
- Stage 2 (edge E1):
  - If s1_v: rsp_data1/2_o <= data_1_i/data_2_i and rsp_valid_o <= onehot(s1_id). Otherwise rsp_valid_o <= 0 and data regs hold.
  - Response is visible in the cycle after E1: latency 2 edges from transfer.
- Back-to-back:
  - Transfers on consecutive cycles produce rsp_valid_o pulses on consecutive cycles, in grant order.
  - A lane may transfer again in the cycle immediately after its previous transfer.
- Lanes must accept responses; there is no response backpressure.
- lookup_cnt_o increments when rsp_valid_o is nonzero and saturates at 2^CNT_W-1.
- idle_o = ~s1_v & ~(|rsp_valid_o) & ~(|req_valid_i), registered.
- A lane dropping req_valid_i without a transfer is legal; no state changes.
- Single lane valid continuously: it is granted every cycle. The pointer still advances, so it wraps back to that lane.

Decomposition:
- Package occ_arb_pkg holds:
  - N_REQ, ADDR_W, DATA_W, CNT_W defaults
  - onehot/index helper functions
- Sub-module rr_arbiter (params N): inputs req[N] and ptr; outputs one-hot gnt[N] and gnt_idx. Purely combinational, reused elsewhere.
- Pipeline registers and counter stay in occ_rom_arbiter.

Test Plan:
- Reset mid-operation: assert rst with a lookup in stage 1 -> no rsp_valid_o pulse ever appears; all outputs 0; idle_o=1.
- Single request: lane 2 valid once with addr1=8'h05, addr2=8'h0A at E0:
  - req_ready_o=4'b0100; ce_rom_Occ_o=1 with addrs 05/0A after E0.
  - rsp_valid_o=4'b0100 after E1, with rsp_data1/2 equal to the rom_Occ model entries for 05/0A.
  - lookup_cnt_o=1.
- All four lanes valid continuously for 8 cycles, ptr=0:
  - Grant order is 0,1,2,3,0,1,2,3.
  - rsp_valid_o follows the same sequence 2 cycles later.
  - lookup_cnt_o=8.
- Lanes 1 and 3 valid, ptr=2 -> lane 3 granted first, then lane 1, then lane 3.
- Idle gap: no valid for 3 cycles -> ce_rom_Occ_o=0, address outputs hold, rsp_valid_o=0, idle_o=1.
- Counter saturation: CNT_W=4 with 20 lookups -> lookup_cnt_o stops at 15.
